// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
// Optional checksum support is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  // Index of a byte within a 32-bit word (0..3)
  localparam int unsigned BYTE_IDX_W = 2;

  // Width of the trailing checksum byte
  localparam int unsigned CSUM_W = 8;

endpackage

// File: rtl/imem_stream_loader_packer.sv
// byte_word_packer: assembles four bytes, LSB first, into a 32-bit word.
// 'last' is high when three bytes are buffered, so the next shift completes
// the word. 'word' only changes when a word completes, so it stays stable
// while the next word is being collected.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic        last,
  output logic [31:0] word
);

  logic [BYTE_IDX_W-1:0] idx;
  logic [23:0]           partial;

  assign last = (idx == '1);

  // Byte index, partial-word buffer and completed-word register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      partial <= '0;
      word    <= '0;
    end else if (clear) begin
      idx     <= '0;
      partial <= '0;
    end else if (shift_en) begin
      if (last) begin
        word <= {byte_in, partial};
        idx  <= '0;
      end else begin
        partial <= {byte_in, partial[23:8]};
        idx     <= idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// imem_stream_loader: fills instruction memory from a byte stream
// (LEN_LO, LEN_HI, then N little-endian words) and holds the CPU in reset
// while loading. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the data.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_wren,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_t END_ST = CSUM;
`else
  localparam loader_state_t END_ST = DONE;
`endif

  loader_state_t    state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] n_hdr;
  logic             xfer;
  logic             load_start;
  logic             last_word;
  logic             pk_last;
  logic             pk_shift;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CSUM_W-1:0] csum_q;
`endif

  assign xfer       = byte_valid && byte_ready;
  assign load_start = start && (state == IDLE || state == DONE || state == ERR);
  assign n_hdr      = LEN_W'({byte_data, len_q[7:0]});
  assign last_word  = (32'(words_loaded) + 32'd1) == 32'(len_q);
  assign pk_shift   = (state == DATA) && xfer;

  // imem_wdata comes straight from the packer's completed-word register,
  // which only changes when a word completes, so it holds between writes.
  byte_word_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (load_start),
    .shift_en (pk_shift),
    .byte_in  (byte_data),
    .last     (pk_last),
    .word     (imem_wdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    imem_wren  = 1'b0;
    cpu_hold   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = LEN_LO;
      LEN_LO: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (xfer) begin
          if (32'(n_hdr) > DEPTH) state_nxt = ERR;
          else if (n_hdr == '0)   state_nxt = END_ST;
          else                    state_nxt = DATA;
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (xfer && pk_last) state_nxt = WRITE;
      end
      WRITE: begin
        imem_wren = 1'b1;
        cpu_hold  = 1'b1;
        busy      = 1'b1;
        state_nxt = last_word ? END_ST : DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        busy       = 1'b1;
        if (xfer) state_nxt = (byte_data == csum_q) ? DONE : ERR;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      ERR: begin
        error    = 1'b1;
        cpu_hold = 1'b1;
        if (start) state_nxt = LEN_LO;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Length, word counter, write address and checksum.
  // imem_addr is captured when a word completes rather than tracking
  // words_loaded, so it holds its value after the write cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q        <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      if (load_start) begin
        len_q        <= '0;
        words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q       <= '0;
`endif
      end
      if (state == LEN_LO && xfer) len_q <= LEN_W'(byte_data);
      if (state == LEN_HI && xfer) len_q <= n_hdr;
      if (pk_shift) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_q <= csum_q ^ byte_data;
`endif
        if (pk_last) imem_addr <= words_loaded[ADDR_W-1:0];
      end
      if (state == WRITE) words_loaded <= words_loaded + 1'b1;
    end
  end

endmodule
